// File: rtl/sram_serial_host.sv
`timescale 1ns/1ps
// Host-side initiator for the serial SRAM load/dump port: MSB-first word shifting plus CEN/WEN strobes.
// Optional: define SRAM_SERIAL_HOST_WR_VERIFY_EN to read back every write and flag mismatches on RSP_ERR.
module sram_serial_host #(
   parameter int ADDRWIDTH = 13,
   parameter int DATAWIDTH = 32,
   parameter int INSTWIDTH = 16,
   parameter int RD_LAT    = 1
) (
   input  logic                 CLK,
   input  logic                 RST,
   input  logic                 REQ_VALID,
   output logic                 REQ_READY,
   input  logic                 REQ_WRITE,
   input  logic                 REQ_MUX,
   input  logic [ADDRWIDTH-1:0] REQ_ADDR,
   input  logic [DATAWIDTH-1:0] REQ_WDATA,
   output logic                 RSP_VALID,
   output logic [DATAWIDTH-1:0] RSP_RDATA,
   output logic                 RSP_ERR,
   output logic                 BUSY,
   output logic                 SRAMSEL,
   output logic [ADDRWIDTH-1:0] SRAMA,
   output logic                 SRAMMUX,
   output logic                 SRAMCEN,
   output logic                 SRAMWEN,
   output logic                 SRAMDIN,
   input  logic                 SRAMDOUT
);

   typedef enum logic [2:0] {
      IDLE   = 3'd0,
      WSHIFT = 3'd1,
      WSTRB  = 3'd2,
      RSTRB  = 3'd3,
      RWAIT  = 3'd4,
      RSHIFT = 3'd5,
      DONE   = 3'd6
   } state_t;

   localparam logic [5:0] CNT_DATA = 6'(DATAWIDTH - 1);
   localparam logic [5:0] CNT_INST = 6'(INSTWIDTH - 1);
   localparam logic [1:0] LAT_INIT = 2'(RD_LAT - 1);

   state_t               state;
   logic [5:0]           cnt;
   logic [1:0]           lat_cnt;
   logic                 write_q;
   logic [DATAWIDTH-1:0] wsh;
   logic [DATAWIDTH-1:0] rsh;
   logic [DATAWIDTH-1:0] wdata_aligned;
   logic [5:0]           cnt_init;

   // INST words are left-aligned so the shifter always emits from the top bit.
   assign wdata_aligned = REQ_MUX ? REQ_WDATA
                                  : {REQ_WDATA[INSTWIDTH-1:0], {(DATAWIDTH-INSTWIDTH){1'b0}}};
   assign cnt_init      = SRAMMUX ? CNT_DATA : CNT_INST;

`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
   logic [DATAWIDTH-1:0] wdata_q;
   logic [DATAWIDTH-1:0] wdata_masked;
   logic                 rsp_err_q;

   assign wdata_masked = REQ_MUX ? REQ_WDATA
                                 : {{(DATAWIDTH-INSTWIDTH){1'b0}}, REQ_WDATA[INSTWIDTH-1:0]};
   assign RSP_ERR      = rsp_err_q;
`else
   assign RSP_ERR      = 1'b0;
`endif

   always_ff @(posedge CLK or posedge RST) begin
      if (RST) begin
         state     <= IDLE;
         cnt       <= '0;
         lat_cnt   <= '0;
         write_q   <= 1'b0;
         wsh       <= '0;
         rsh       <= '0;
         REQ_READY <= 1'b1;
         RSP_VALID <= 1'b0;
         RSP_RDATA <= '0;
         BUSY      <= 1'b0;
         SRAMSEL   <= 1'b0;
         SRAMA     <= '0;
         SRAMMUX   <= 1'b0;
         SRAMCEN   <= 1'b1;
         SRAMWEN   <= 1'b1;
         SRAMDIN   <= 1'b0;
`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
         wdata_q   <= '0;
         rsp_err_q <= 1'b0;
`endif
      end else begin
         RSP_VALID <= 1'b0;
`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
         rsp_err_q <= 1'b0;
`endif
         case (state)
            IDLE: begin
               if (REQ_VALID && REQ_READY) begin
                  REQ_READY <= 1'b0;
                  BUSY      <= 1'b1;
                  SRAMSEL   <= 1'b1;
                  SRAMA     <= REQ_ADDR;
                  SRAMMUX   <= REQ_MUX;
                  write_q   <= REQ_WRITE;
                  wsh       <= wdata_aligned;
                  cnt       <= REQ_MUX ? CNT_DATA : CNT_INST;
`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
                  wdata_q   <= wdata_masked;
`endif
                  if (REQ_WRITE) begin
                     state   <= WSHIFT;
                     SRAMDIN <= wdata_aligned[DATAWIDTH-1];
                  end else begin
                     state   <= RSTRB;
                     SRAMCEN <= 1'b0;
                  end
               end
            end

            // Each WSHIFT cycle presents the next bit; the strobe follows only after bit 0.
            WSHIFT: begin
               if (cnt == 6'd0) begin
                  state   <= WSTRB;
                  SRAMDIN <= 1'b0;
                  SRAMCEN <= 1'b0;
                  SRAMWEN <= 1'b0;
               end else begin
                  cnt     <= cnt - 6'd1;
                  wsh     <= wsh << 1;
                  SRAMDIN <= wsh[DATAWIDTH-2];
               end
            end

            WSTRB: begin
               SRAMWEN <= 1'b1;
`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
               state   <= RSTRB;
               SRAMCEN <= 1'b0;
`else
               state   <= DONE;
               SRAMCEN <= 1'b1;
`endif
            end

            RSTRB: begin
               SRAMCEN <= 1'b1;
               rsh     <= '0;
               if (RD_LAT == 0) begin
                  state <= RSHIFT;
                  cnt   <= cnt_init;
               end else begin
                  state   <= RWAIT;
                  lat_cnt <= LAT_INIT;
               end
            end

            RWAIT: begin
               if (lat_cnt == 2'd0) begin
                  state <= RSHIFT;
                  cnt   <= cnt_init;
               end else begin
                  lat_cnt <= lat_cnt - 2'd1;
               end
            end

            // rsh was cleared at the strobe, so INST reads come out zero-extended.
            RSHIFT: begin
               rsh <= {rsh[DATAWIDTH-2:0], SRAMDOUT};
               if (cnt == 6'd0) begin
                  state <= DONE;
               end else begin
                  cnt <= cnt - 6'd1;
               end
            end

            DONE: begin
               state     <= IDLE;
               REQ_READY <= 1'b1;
               BUSY      <= 1'b0;
               SRAMSEL   <= 1'b0;
               RSP_VALID <= 1'b1;
`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
               RSP_RDATA <= rsh;
               rsp_err_q <= write_q && (rsh != wdata_q);
`else
               if (!write_q) begin
                  RSP_RDATA <= rsh;
               end
`endif
            end

            default: state <= IDLE;
         endcase
      end
   end

endmodule

// File: tb/tb_sram_serial_host.sv
`timescale 1ns/1ps
// Directed bench for sram_serial_host: write/read transfers, handshake spacing and mid-transfer reset.
module tb_sram_serial_host;

   localparam int ADDRWIDTH = 13;
   localparam int DATAWIDTH = 32;
   localparam int INSTWIDTH = 16;
   localparam int RD_LAT    = 1;
`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
   localparam bit VERIFY = 1'b1;
`else
   localparam bit VERIFY = 1'b0;
`endif

   logic                 CLK = 1'b0;
   logic                 RST;
   logic                 REQ_VALID, REQ_READY, REQ_WRITE, REQ_MUX;
   logic [ADDRWIDTH-1:0] REQ_ADDR;
   logic [DATAWIDTH-1:0] REQ_WDATA;
   logic                 RSP_VALID, RSP_ERR, BUSY;
   logic [DATAWIDTH-1:0] RSP_RDATA;
   logic                 SRAMSEL, SRAMMUX, SRAMCEN, SRAMWEN, SRAMDIN, SRAMDOUT;
   logic [ADDRWIDTH-1:0] SRAMA;

   always #5 CLK = ~CLK;

   sram_serial_host #(
      .ADDRWIDTH(ADDRWIDTH), .DATAWIDTH(DATAWIDTH), .INSTWIDTH(INSTWIDTH), .RD_LAT(RD_LAT)
   ) dut (
      .CLK(CLK), .RST(RST),
      .REQ_VALID(REQ_VALID), .REQ_READY(REQ_READY), .REQ_WRITE(REQ_WRITE), .REQ_MUX(REQ_MUX),
      .REQ_ADDR(REQ_ADDR), .REQ_WDATA(REQ_WDATA),
      .RSP_VALID(RSP_VALID), .RSP_RDATA(RSP_RDATA), .RSP_ERR(RSP_ERR), .BUSY(BUSY),
      .SRAMSEL(SRAMSEL), .SRAMA(SRAMA), .SRAMMUX(SRAMMUX), .SRAMCEN(SRAMCEN),
      .SRAMWEN(SRAMWEN), .SRAMDIN(SRAMDIN), .SRAMDOUT(SRAMDOUT)
   );

   int n_checks = 0;
   int n_fail   = 0;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, got, exp);
      end
   endtask

   // SRAM read model: after a read strobe, RD_LAT idle cycles, then the word MSB-first.
   logic [31:0] model_word;
   initial begin
      SRAMDOUT = 1'b0;
      forever begin
         @(posedge CLK);
         if (SRAMCEN === 1'b0 && SRAMWEN === 1'b1) begin
            automatic int w = SRAMMUX ? DATAWIDTH : INSTWIDTH;
            for (int l = 0; l < RD_LAT; l++) @(posedge CLK);
            for (int i = w - 1; i >= 0; i--) begin
               #1 SRAMDOUT = model_word[i];
               @(posedge CLK);
            end
            #1 SRAMDOUT = 1'b0;
         end
      end
   end

   int          lat, wstb_n, rstb_n, din_n, early_ready;
   logic [31:0] din_bits, rdata, stb_addr;
   logic        stb_mux, stb_din, err, cur_write;

   task automatic issue(input logic wr, input logic mux, input logic [12:0] addr,
                        input logic [31:0] wd, input bit hold);
      REQ_WRITE = wr; REQ_MUX = mux; REQ_ADDR = addr; REQ_WDATA = wd; REQ_VALID = 1'b1;
      cur_write = wr;
      for (int i = 0; i < 100 && !REQ_READY; i++) begin
         @(posedge CLK); #1;
      end
      @(posedge CLK); #1;
      if (!hold) REQ_VALID = 1'b0;
   endtask

   // Sample index c counts cycles after the acceptance edge; lat stays 0 on timeout.
   task automatic watch();
      lat = 0; wstb_n = 0; rstb_n = 0; din_n = 0; early_ready = 0;
      din_bits = '0; rdata = '0; stb_addr = '0; stb_mux = 1'b0; stb_din = 1'b0; err = 1'b0;
      for (int c = 0; c < 200; c++) begin
         if (!SRAMCEN && !SRAMWEN) begin
            wstb_n++; stb_addr = 32'(SRAMA); stb_mux = SRAMMUX; stb_din = SRAMDIN;
         end else if (!SRAMCEN) begin
            rstb_n++; stb_addr = 32'(SRAMA); stb_mux = SRAMMUX;
         end else if (cur_write && wstb_n == 0 && rstb_n == 0) begin
            din_bits = {din_bits[30:0], SRAMDIN}; din_n++;
         end
         if (RSP_VALID) begin
            lat = c; rdata = RSP_RDATA; err = RSP_ERR;
            break;
         end
         if (REQ_READY) early_ready++;
         @(posedge CLK); #1;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      RST = 1'b1; REQ_VALID = 1'b0; REQ_WRITE = 1'b0; REQ_MUX = 1'b0;
      REQ_ADDR = '0; REQ_WDATA = '0; model_word = '0; cur_write = 1'b0;
      repeat (3) @(posedge CLK);
      #1 RST = 1'b0;
      #1;
      // {READY,BUSY,RSP_VALID,RSP_ERR,SEL,CEN,WEN,DIN,MUX}
      check("rst_ctrl", 32'({REQ_READY, BUSY, RSP_VALID, RSP_ERR, SRAMSEL, SRAMCEN, SRAMWEN, SRAMDIN, SRAMMUX}),
            32'b1_0_0_0_0_1_1_0_0);
      check("rst_addr", 32'(SRAMA), 32'h0);
      check("rst_rdata", RSP_RDATA, 32'h0);

      // DATA write
      model_word = 32'hA5C3_0F01;
      issue(1'b1, 1'b1, 13'h1ABC, 32'hA5C3_0F01, 1'b0);
      watch();
      check("dw_lat", lat, VERIFY ? 68 : 34);
      check("dw_bits", din_bits, 32'hA5C3_0F01);
      check("dw_nbits", din_n, 32);
      check("dw_wstb", wstb_n, 1);
      check("dw_rstb", rstb_n, VERIFY ? 1 : 0);
      check("dw_addr", stb_addr, 32'h1ABC);
      check("dw_mux", 32'(stb_mux), 32'h1);
      check("dw_din_at_stb", 32'(stb_din), 32'h0);
      check("dw_err", 32'(err), 32'h0);
      check("dw_rdata", rdata, VERIFY ? 32'hA5C3_0F01 : 32'h0);
      @(posedge CLK); #1;
      check("dw_after", 32'({RSP_VALID, REQ_READY, BUSY, SRAMSEL}), 32'b0100);

      // DATA read
      model_word = 32'h1234_5678;
      issue(1'b0, 1'b1, 13'h0123, 32'h0, 1'b0);
      watch();
      check("dr_lat", lat, 35);
      check("dr_rdata", rdata, 32'h1234_5678);
      check("dr_rstb", rstb_n, 1);
      check("dr_wstb", wstb_n, 0);
      check("dr_addr", stb_addr, 32'h0123);
      check("dr_err", 32'(err), 32'h0);

      // INST write: only the low 16 bits go out
      model_word = 32'h0000_BEEF;
      issue(1'b1, 1'b0, 13'h007F, 32'hFFFF_BEEF, 1'b0);
      watch();
      check("iw_lat", lat, VERIFY ? 36 : 18);
      check("iw_bits", din_bits, 32'h0000_BEEF);
      check("iw_nbits", din_n, 16);
      check("iw_wstb", wstb_n, 1);
      check("iw_addr", stb_addr, 32'h007F);
      check("iw_mux", 32'(stb_mux), 32'h0);
      check("iw_rdata", rdata, VERIFY ? 32'h0000_BEEF : 32'h1234_5678);

      // INST read with REQ_VALID held: next request accepted only after DONE
      model_word = 32'h0000_C0DE;
      issue(1'b0, 1'b0, 13'h0055, 32'h0, 1'b1);
      watch();
      check("ir_lat", lat, 19);
      check("ir_rdata", rdata, 32'h0000_C0DE);
      check("ir_early_ready", early_ready, 0);
      check("ir_ready_done", 32'(REQ_READY), 32'h1);
      model_word = 32'h0000_1111;
      @(posedge CLK); #1;
      REQ_VALID = 1'b0;
      watch();
      check("ir2_lat", lat, 19);
      check("ir2_rdata", rdata, 32'h0000_1111);

`ifdef SRAM_SERIAL_HOST_WR_VERIFY_EN
      model_word = 32'hDEAD_BEEE;
      issue(1'b1, 1'b1, 13'h0200, 32'hDEAD_BEEF, 1'b0);
      watch();
      check("vf_bad_err", 32'(err), 32'h1);
      check("vf_bad_rdata", rdata, 32'hDEAD_BEEE);
      check("vf_bad_lat", lat, 68);
      model_word = 32'hDEAD_BEEF;
      issue(1'b1, 1'b1, 13'h0200, 32'hDEAD_BEEF, 1'b0);
      watch();
      check("vf_ok_err", 32'(err), 32'h0);
      check("vf_ok_rdata", rdata, 32'hDEAD_BEEF);
`endif

      // Reset in the middle of WSHIFT
      issue(1'b1, 1'b1, 13'h1ABC, 32'hA5C3_0F01, 1'b0);
      repeat (4) begin @(posedge CLK); #1; end
      check("mid_busy", 32'({BUSY, SRAMSEL}), 32'b11);
      RST = 1'b1;
      #1;
      check("mid_rst_ctrl", 32'({REQ_READY, BUSY, RSP_VALID, RSP_ERR, SRAMSEL, SRAMCEN, SRAMWEN, SRAMDIN, SRAMMUX}),
            32'b1_0_0_0_0_1_1_0_0);
      check("mid_rst_addr", 32'(SRAMA), 32'h0);
      #1 RST = 1'b0;
      begin
         automatic int lows = 0;
         repeat (40) begin
            @(posedge CLK); #1;
            if (!SRAMCEN || !SRAMWEN || RSP_VALID || SRAMSEL) lows++;
         end
         check("mid_no_strobe", lows, 0);
      end

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
